valid_ready_pipe: RTL and testbench

//   Backpressure-capable pipeline delay: carries a data word and its valid

---
 rtl/valid_ready_pipe.sv | 139 +++++++++++++
 tb/tb_valid_ready_pipe.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/valid_ready_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : valid_ready_pipe
//  Purpose  : Backpressure-capable pipeline delay. Carries a data word and its
//             valid qualifier through DELAY skid-buffered register slices and
//             propagates ready in the opposite direction. Every ready output
//             is registered, so no combinational path runs from o_ready to
//             i_ready. DELAY=0 degenerates to plain wires.
//  Revision : 1.0  initial release
// ============================================================================
module valid_ready_pipe #(
  parameter int DELAY = 1,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             o_ready
);

  // Per-slice occupancy: EMPTY holds nothing, BUSY holds the main register,
  // FULL holds both the main and the skid register.
  typedef enum logic [1:0] {
    c_EMPTY = 2'd0,
    c_BUSY  = 2'd1,
    c_FULL  = 2'd2
  } state_t;

  generate
    if (DELAY == 0) begin : g_pass
      // Pure passthrough; clock and reset have no function here.
      logic w_unused;
      assign w_unused = clk ^ reset_l;
      assign o_data   = i_data;
      assign o_valid  = i_valid;
      assign i_ready  = o_ready;
    end else begin : g_pipe
      // Index k is the interface feeding slice k; index DELAY is the output.
      logic [DELAY:0][WIDTH-1:0] w_data;
      logic [DELAY:0]            w_valid;
      logic [DELAY:0]            w_ready;

      assign w_data[0]      = i_data;
      assign w_valid[0]     = i_valid;
      assign i_ready        = w_ready[0];
      assign o_data         = w_data[DELAY];
      assign o_valid        = w_valid[DELAY];
      assign w_ready[DELAY] = o_ready;

      for (genvar k = 0; k < DELAY; k++) begin : g_stage
        state_t           r_state;
        logic             r_valid;
        logic             r_ready;
        logic [WIDTH-1:0] r_main;
        logic [WIDTH-1:0] r_skid;
        logic             w_load;
        logic             w_drain;
        logic             w_main_en;
        logic             w_main_from_skid;
        logic             w_skid_en;

        // A word moves only where valid and ready meet on the same edge.
        assign w_load  = w_valid[k] & r_ready;
        assign w_drain = r_valid & w_ready[k+1];

        // Main reloads when it is free, when it is replaced in the same
        // cycle it drains, or when the skid word moves forward.
        assign w_main_en        = ((r_state == c_EMPTY) && w_load) ||
                                  ((r_state == c_BUSY) && w_load && w_drain) ||
                                  ((r_state == c_FULL) && w_drain);
        assign w_main_from_skid = (r_state == c_FULL);
        // The skid catches the word accepted while the output is stalled.
        assign w_skid_en        = (r_state == c_BUSY) && w_load && !w_drain;

        assign w_ready[k]   = r_ready;
        assign w_valid[k+1] = r_valid;
        assign w_data[k+1]  = r_main;

        // Slice FSM with registered valid/ready; reset overrides any transfer.
        always_ff @(posedge clk) begin
          if (!reset_l) begin
            r_state <= c_EMPTY;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
          end else begin
            case (r_state)
              c_EMPTY: begin
                if (w_load) begin
                  r_state <= c_BUSY;
                  r_valid <= 1'b1;
                  r_ready <= 1'b1;
                end
              end
              c_BUSY: begin
                if (w_load && !w_drain) begin
                  r_state <= c_FULL;
                  r_valid <= 1'b1;
                  r_ready <= 1'b0;
                end else if (!w_load && w_drain) begin
                  r_state <= c_EMPTY;
                  r_valid <= 1'b0;
                  r_ready <= 1'b1;
                end
              end
              c_FULL: begin
                if (w_drain) begin
                  r_state <= c_BUSY;
                  r_valid <= 1'b1;
                  r_ready <= 1'b1;
                end
              end
              default: begin
                r_state <= c_EMPTY;
                r_valid <= 1'b0;
                r_ready <= 1'b1;
              end
            endcase
          end
        end

        // Data registers carry no reset; contents are ignored while invalid.
        always_ff @(posedge clk) begin
          if (w_main_en) begin
            r_main <= w_main_from_skid ? r_skid : w_data[k];
          end
          if (w_skid_en) begin
            r_skid <= w_data[k];
          end
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_valid_ready_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_valid_ready_pipe
//  Purpose  : Self-checking bench for valid_ready_pipe. Four instances
//             (DELAY 0/2/3/4) share one stimulus bus; a selector chooses which
//             instance's outputs are scored against a queue of accepted words.
//  Revision : 1.0  initial release
// ============================================================================
module tb_valid_ready_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_l;
  logic [W-1:0] i_data;
  logic         i_valid;
  logic         o_ready;

  logic [W-1:0] od0, od2, od3, od4;
  logic         ov0, ov2, ov3, ov4;
  logic         ir0, ir2, ir3, ir4;

  always #5 clk = ~clk;

  valid_ready_pipe #(.DELAY(0), .WIDTH(W)) u_d0 (
    .clk(clk), .reset_l(reset_l), .i_data(i_data), .i_valid(i_valid),
    .i_ready(ir0), .o_data(od0), .o_valid(ov0), .o_ready(o_ready));
  valid_ready_pipe #(.DELAY(2), .WIDTH(W)) u_d2 (
    .clk(clk), .reset_l(reset_l), .i_data(i_data), .i_valid(i_valid),
    .i_ready(ir2), .o_data(od2), .o_valid(ov2), .o_ready(o_ready));
  valid_ready_pipe #(.DELAY(3), .WIDTH(W)) u_d3 (
    .clk(clk), .reset_l(reset_l), .i_data(i_data), .i_valid(i_valid),
    .i_ready(ir3), .o_data(od3), .o_valid(ov3), .o_ready(o_ready));
  valid_ready_pipe #(.DELAY(4), .WIDTH(W)) u_d4 (
    .clk(clk), .reset_l(reset_l), .i_data(i_data), .i_valid(i_valid),
    .i_ready(ir4), .o_data(od4), .o_valid(ov4), .o_ready(o_ready));

  int           sel;
  logic [W-1:0] m_odata;
  logic         m_ovalid;
  logic         m_iready;

  // Route the selected instance to the monitor.
  always_comb begin
    m_odata  = od3;
    m_ovalid = ov3;
    m_iready = ir3;
    case (sel)
      0: begin m_odata = od0; m_ovalid = ov0; m_iready = ir0; end
      2: begin m_odata = od2; m_ovalid = ov2; m_iready = ir2; end
      4: begin m_odata = od4; m_ovalid = ov4; m_iready = ir4; end
      default: ;
    endcase
  end

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] sb[$];
  int           cyc = 0;
  int           first_in, first_out, last_out, n_acc, n_out;
  logic         s_ivalid, s_iready, s_ovalid, s_oready;
  logic [W-1:0] s_idata, s_odata, stall_data, nxt;
  logic         stall_prev, in_stalled;
  logic [W:0]   exp_word;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    sb.delete();
    n_acc = 0; n_out = 0;
    first_in = -1; first_out = -1; last_out = -1;
    stall_prev = 1'b0; in_stalled = 1'b0;
  endtask

  // One clock: sample at the falling edge, score transfers, then return
  // 1 time unit after the rising edge so the caller can drive new inputs.
  task automatic step();
    @(negedge clk);
    s_ivalid = i_valid; s_idata = i_data; s_oready = o_ready;
    s_iready = m_iready; s_ovalid = m_ovalid; s_odata = m_odata;
    if (sel != 0 && stall_prev)
      check("stall_hold", {15'b0, s_ovalid, s_odata}, {15'b0, 1'b1, stall_data});
    if (sel == 2 && !s_iready && reset_l)
      check("iready_low_occupancy_ge3", 32'(sb.size() >= 3), 32'd1);
    if (reset_l && s_ivalid && s_iready) begin
      sb.push_back(s_idata);
      n_acc++;
      if (first_in < 0) first_in = cyc;
    end
    if (reset_l && s_ovalid && s_oready) begin
      exp_word = (sb.size() > 0) ? {1'b1, sb.pop_front()} : '0;
      check("out_data", {15'b0, 1'b1, s_odata}, {15'b0, exp_word});
      n_out++;
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
    end
    stall_prev = reset_l && s_ovalid && !s_oready;
    stall_data = s_odata;
    in_stalled = s_ivalid && !s_iready;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_l = 1'b0; i_valid = 1'b0; o_ready = 1'b0;
    step(); step();
    reset_l = 1'b1;
    clear_stats();
  endtask

  // Offer consecutive words; data holds while the pipe refuses it.
  task automatic stream_until(input int words, input int budget);
    for (int g = 0; g < budget && int'(nxt) < words; g++) begin
      i_valid = 1'b1; i_data = nxt;
      step();
      if (s_ivalid && s_iready) nxt++;
    end
    i_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    i_valid = 1'b0; o_ready = 1'b1;
    for (int g = 0; g < budget && sb.size() > 0; g++) step();
    check(tag, sb.size(), 0);
  endtask

  logic [W-1:0] p_data [4] = '{16'h1234, 16'hABCD, 16'h0000, 16'hFFFF};
  logic         p_valid[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic         p_ready[4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    sel = 3; i_data = '0; nxt = '0;
    do_reset();
    check("rst_ovalid_d2", {31'b0, ov2}, 32'd0);
    check("rst_iready_d2", {31'b0, ir2}, 32'd1);
    check("rst_ovalid_d3", {31'b0, ov3}, 32'd0);
    check("rst_iready_d3", {31'b0, ir3}, 32'd1);
    check("rst_ovalid_d4", {31'b0, ov4}, 32'd0);
    check("rst_iready_d4", {31'b0, ir4}, 32'd1);

    // Back-to-back stream through three slices with no backpressure.
    sel = 3; do_reset();
    o_ready = 1'b1; nxt = '0;
    stream_until(10, 40);
    drain("t1_drained", 40);
    check("t1_latency", first_out - first_in, 3);
    check("t1_contiguous", last_out - first_out, 9);
    check("t1_count", n_out, 10);

    // Fill with output stalled, then release.
    sel = 3; do_reset();
    o_ready = 1'b0; nxt = '0;
    for (int g = 0; g < 12; g++) begin
      i_valid = 1'b1; i_data = nxt;
      step();
      if (s_ivalid && s_iready) nxt++;
    end
    check("t2_accepted", n_acc, 6);
    check("t2_iready_low", {31'b0, m_iready}, 32'd0);
    o_ready = 1'b1;
    for (int g = 0; g < 20; g++) begin
      i_valid = 1'b1; i_data = nxt;
      step();
      if (s_ivalid && s_iready) nxt++;
    end
    check("t2_resumed", 32'(n_acc > 6), 32'd1);
    drain("t2_drained", 40);

    // Alternating backpressure against a saturating producer.
    sel = 2; do_reset();
    o_ready = 1'b1; nxt = '0;
    for (int g = 0; g < 40; g++) begin
      i_valid = 1'b1; i_data = nxt;
      step();
      if (s_ivalid && s_iready) nxt++;
      o_ready = ~o_ready;
    end
    drain("t3_drained", 40);
    check("t3_lossless", n_out, n_acc);

    // Reset with words in flight discards them.
    sel = 3; do_reset();
    o_ready = 1'b0; nxt = '0;
    stream_until(4, 20);
    check("t4_inflight", n_acc, 4);
    reset_l = 1'b0;
    step();
    reset_l = 1'b1;
    clear_stats();
    check("t4_ovalid_after_rst", {31'b0, m_ovalid}, 32'd0);
    check("t4_iready_after_rst", {31'b0, m_iready}, 32'd1);
    o_ready = 1'b1;
    for (int g = 0; g < 10; g++) step();
    check("t4_no_ghosts", n_out, 0);
    nxt = 16'd100;
    stream_until(103, 20);
    drain("t4_drained", 20);
    check("t4_new_words", n_out, 3);

    // Zero-delay passthrough.
    sel = 0;
    for (int p = 0; p < 4; p++) begin
      i_data = p_data[p]; i_valid = p_valid[p]; o_ready = p_ready[p];
      #1;
      check("t5_odata", {16'b0, od0}, {16'b0, p_data[p]});
      check("t5_ovalid", {31'b0, ov0}, {31'b0, p_valid[p]});
      check("t5_iready", {31'b0, ir0}, {31'b0, p_ready[p]});
    end

    // Random traffic against the scoreboard.
    sel = 4; do_reset();
    nxt = '0;
    for (int g = 0; g < 10000; g++) begin
      o_ready = 1'($urandom_range(0, 1));
      if (!in_stalled) i_valid = 1'($urandom_range(0, 1));
      i_data = nxt;
      step();
      if (s_ivalid && s_iready) nxt++;
    end
    drain("t6_drained", 60);
    check("t6_lossless", n_out, n_acc);
    check("t6_activity", 32'(n_acc > 1000), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
